i_decode: RTL and testbench

I_DECODE -- requirements
Module: i_decode

---
 rtl/i_decode_pkg.sv | 43 ++++
 rtl/i_decode_register_file.sv | 53 +++++
 rtl/i_decode.sv | 95 +++++++++
 tb/tb_i_decode.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/i_decode_pkg.sv
// Shared pipeline definitions: opcodes, IF/ID field positions and
// ID/EX control-field layouts and encodings.
package i_decode_pkg;

  // IF/ID instruction field positions
  localparam int OP_LSB  = 26;
  localparam int OP_W    = 6;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int IMM_W   = 16;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  // WB bundle: {RegWrite, MemtoReg}
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  // M bundle: {Branch, MemRead, MemWrite}
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;
  // EX bundle: {RegDst, ALUOp[1:0], ALUSrc}
  localparam int EX_REGDST   = 3;
  localparam int EX_ALUOP_LSB = 1;
  localparam int EX_ALUSRC   = 0;

  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] m;
    logic [3:0] ex;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP   = '{wb: 2'b00, m: 3'b000, ex: 4'b0000};
  localparam ctrl_t CTRL_RTYPE = '{wb: 2'b10, m: 3'b000, ex: 4'b1100};
  localparam ctrl_t CTRL_LW    = '{wb: 2'b11, m: 3'b010, ex: 4'b0001};
  localparam ctrl_t CTRL_SW    = '{wb: 2'b00, m: 3'b001, ex: 4'b0001};
  localparam ctrl_t CTRL_BEQ   = '{wb: 2'b00, m: 3'b100, ex: 4'b0010};

endpackage

// File: rtl/i_decode_register_file.sv
// Register file: two async read ports, one sync write port with
// write-through bypass, sync reset. Register 0 reads as zero.
// Ports: clk, reset, ra1/ra2 -> rd1/rd2, we/wa/wd write port.
module register_file #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  // A nonzero ra implies wa is nonzero when they match,
  // so the bypass never leaks a write to r0.
  always_comb begin
    rd1 = regs[ra1];
    if (ra1 == '0) begin
      rd1 = '0;
    end else if (we && wa == ra1) begin
      rd1 = wd;
    end
  end

  always_comb begin
    rd2 = regs[ra2];
    if (ra2 == '0) begin
      rd2 = '0;
    end else if (we && wa == ra2) begin
      rd2 = wd;
    end
  end

endmodule

// File: rtl/i_decode.sv
// Instruction decode stage: control decode, register read and ID/EX
// register. Inputs IF_ID_*, flush, WB_* writeback; outputs ID_EX_*.
module i_decode
  import i_decode_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      IF_ID_IR,
  input  logic [WIDTH-1:0]      IF_ID_NPC,
  input  logic                  flush,
  input  logic                  WB_RegWrite,
  input  logic [REG_ADDR_W-1:0] WB_write_reg,
  input  logic [WIDTH-1:0]      WB_write_data,
  output logic [1:0]            ID_EX_WB,
  output logic [2:0]            ID_EX_M,
  output logic [3:0]            ID_EX_EX,
  output logic [WIDTH-1:0]      ID_EX_NPC,
  output logic [WIDTH-1:0]      ID_EX_RD1,
  output logic [WIDTH-1:0]      ID_EX_RD2,
  output logic [WIDTH-1:0]      ID_EX_IMM,
  output logic [REG_ADDR_W-1:0] ID_EX_RT,
  output logic [REG_ADDR_W-1:0] ID_EX_RD
);

  logic [OP_W-1:0]       op;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rd;
  logic [WIDTH-1:0]      imm;
  logic [WIDTH-1:0]      rd1;
  logic [WIDTH-1:0]      rd2;
  ctrl_t                 ctrl;

  assign op  = IF_ID_IR[OP_LSB +: OP_W];
  assign rs  = IF_ID_IR[RS_LSB +: REG_ADDR_W];
  assign rt  = IF_ID_IR[RT_LSB +: REG_ADDR_W];
  assign rd  = IF_ID_IR[RD_LSB +: REG_ADDR_W];
  assign imm = {{(WIDTH-IMM_W){IF_ID_IR[IMM_W-1]}},
                IF_ID_IR[IMM_W-1:0]};

  always_comb begin
    ctrl = CTRL_NOP;
    unique case (1'b1)
      (op == OP_RTYPE): ctrl = CTRL_RTYPE;
      (op == OP_LW):    ctrl = CTRL_LW;
      (op == OP_SW):    ctrl = CTRL_SW;
      (op == OP_BEQ):   ctrl = CTRL_BEQ;
      default:          ctrl = CTRL_NOP;
    endcase
  end

  register_file #(
    .WIDTH  (WIDTH),
    .ADDR_W (REG_ADDR_W)
  ) u_rf (
    .clk   (clk),
    .reset (reset),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (rd1),
    .rd2   (rd2),
    .we    (WB_RegWrite),
    .wa    (WB_write_reg),
    .wd    (WB_write_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ID_EX_WB  <= '0;
      ID_EX_M   <= '0;
      ID_EX_EX  <= '0;
      ID_EX_NPC <= '0;
      ID_EX_RD1 <= '0;
      ID_EX_RD2 <= '0;
      ID_EX_IMM <= '0;
      ID_EX_RT  <= '0;
      ID_EX_RD  <= '0;
    end else begin
      // A flush only kills the control bundles; data still flows.
      ID_EX_WB  <= flush ? 2'b00  : ctrl.wb;
      ID_EX_M   <= flush ? 3'b000 : ctrl.m;
      ID_EX_EX  <= flush ? 4'b0000 : ctrl.ex;
      ID_EX_NPC <= IF_ID_NPC;
      ID_EX_RD1 <= rd1;
      ID_EX_RD2 <= rd2;
      ID_EX_IMM <= imm;
      ID_EX_RT  <= rt;
      ID_EX_RD  <= rd;
    end
  end

endmodule

// File: tb/tb_i_decode.sv
// Scoreboard bench for i_decode: directed cases then random traffic
// checked against a register-array reference model.
module tb_i_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir, npc, wdata;
  logic        flush, we;
  logic [4:0]  wreg;
  logic [1:0]  o_wb;
  logic [2:0]  o_m;
  logic [3:0]  o_ex;
  logic [31:0] o_npc, o_rd1, o_rd2, o_imm;
  logic [4:0]  o_rt, o_rd;

  always #5 clk = ~clk;

  i_decode dut (
    .clk           (clk),
    .reset         (reset),
    .IF_ID_IR      (ir),
    .IF_ID_NPC     (npc),
    .flush         (flush),
    .WB_RegWrite   (we),
    .WB_write_reg  (wreg),
    .WB_write_data (wdata),
    .ID_EX_WB      (o_wb),
    .ID_EX_M       (o_m),
    .ID_EX_EX      (o_ex),
    .ID_EX_NPC     (o_npc),
    .ID_EX_RD1     (o_rd1),
    .ID_EX_RD2     (o_rd2),
    .ID_EX_IMM     (o_imm),
    .ID_EX_RT      (o_rt),
    .ID_EX_RD      (o_rd)
  );

  typedef struct {
    logic [8:0]  ctrl;
    logic [31:0] npc, rd1, rd2, imm;
    logic [4:0]  rt, rd;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model[32];
  int          checks = 0;
  int          errors = 0;

  // {WB, M, EX} per opcode, straight from the opcode table.
  function automatic logic [8:0] ref_ctrl(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b10_000_1100;
      6'h23:   return 9'b11_010_0001;
      6'h2B:   return 9'b00_001_0001;
      6'h04:   return 9'b00_100_0010;
      default: return 9'b0;
    endcase
  endfunction

  // A write in flight is visible to a same-cycle read; r0 is zero.
  function automatic logic [31:0] ref_read(input int r);
    if (r == 0) return 32'h0;
    if (we && int'(wreg) == r) return wdata;
    return model[r];
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [31:0] i,
                      input logic [31:0] n, input logic fl,
                      input logic w, input logic [4:0] wr,
                      input logic [31:0] wd);
    exp_t e;
    @(negedge clk);
    reset = rst; ir = i; npc = n; flush = fl;
    we = w; wreg = wr; wdata = wd;
    if (rst) begin
      e = '{ctrl: 9'b0, npc: 0, rd1: 0, rd2: 0, imm: 0, rt: 0, rd: 0};
      for (int k = 0; k < 32; k++) model[k] = 32'h0;
    end else begin
      e.ctrl = fl ? 9'b0 : ref_ctrl(i[31:26]);
      e.npc  = n;
      e.rd1  = ref_read(int'(i[25:21]));
      e.rd2  = ref_read(int'(i[20:16]));
      e.imm  = 32'(signed'(i[15:0]));
      e.rt   = i[20:16];
      e.rd   = i[15:11];
      if (w && wr != 0) model[wr] = wd;
    end
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("wb",  32'(o_wb),  32'(e.ctrl[8:7]));
      chk("m",   32'(o_m),   32'(e.ctrl[6:4]));
      chk("ex",  32'(o_ex),  32'(e.ctrl[3:0]));
      chk("npc", o_npc, e.npc);
      chk("rd1", o_rd1, e.rd1);
      chk("rd2", o_rd2, e.rd2);
      chk("imm", o_imm, e.imm);
      chk("rt",  32'(o_rt),  32'(e.rt));
      chk("rd",  32'(o_rd),  32'(e.rd));
    end
  end

  initial begin
    logic [5:0]  ops[5];
    logic [31:0] ri;
    reset = 1'b1; ir = 0; npc = 0; flush = 0;
    we = 0; wreg = 0; wdata = 0;
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04;

    step(1, 32'h0, 32'h0, 0, 1, 5'd3, 32'h1111);
    step(1, 32'h0, 32'h0, 0, 0, 5'd0, 32'h0);
    step(0, 32'h00A00000, 32'h4, 0, 0, 5'd0, 32'h0);
    step(0, 32'h00600000, 32'h8, 0, 1, 5'd8, 32'hDEADBEEF);
    step(0, 32'h01095020, 32'hC, 0, 0, 5'd0, 32'h0);
    step(0, 32'h01095020, 32'h10, 0, 1, 5'd9, 32'h00000042);
    step(0, 32'h8D2AFFFC, 32'h14, 0, 0, 5'd0, 32'h0);
    step(0, 32'h1109000C, 32'h18, 1, 1, 5'd0, 32'h1234);
    step(0, 32'h00004000, 32'h1C, 0, 1, 5'd7, 32'h77);
    step(0, 32'hFC000000, 32'h20, 0, 0, 5'd0, 32'h0);
    step(0, 32'h00E84020, 32'h24, 0, 0, 5'd0, 32'h0);

    for (int c = 0; c < 400; c++) begin
      ops[4] = 6'($urandom);
      ri = $urandom;
      ri[31:26] = ops[$urandom_range(0, 4)];
      step($urandom_range(0, 49) == 0, ri, $urandom,
           $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0,
           5'($urandom), $urandom);
    end

    repeat (3) @(negedge clk);
    chk("drain", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
